// File: rtl/if_neuron_scheduler_if.sv
// Host/consumer-side bundle for the time-multiplexed integrate-and-fire scheduler:
// configuration writes, sweep control, spike event stream and state readback.
interface if_neuron_scheduler_if #(
    parameter int IW = 3
);
    logic          thr_we;
    logic [7:0]    thr_data;
    logic          cur_we;
    logic [IW-1:0] cur_idx;
    logic [7:0]    cur_data;
    logic          cur_ready;
    logic          step_start;
    logic          busy;
    logic          done;
    logic          spike_valid;
    logic [IW-1:0] spike_idx;
    logic          spike_ready;
    logic [IW-1:0] rd_idx;
    logic [7:0]    rd_state;

    modport master (
        output thr_we, thr_data, cur_we, cur_idx, cur_data, step_start, spike_ready, rd_idx,
        input  cur_ready, busy, done, spike_valid, spike_idx, rd_state
    );

    modport slave (
        input  thr_we, thr_data, cur_we, cur_idx, cur_data, step_start, spike_ready, rd_idx,
        output cur_ready, busy, done, spike_valid, spike_idx, rd_state
    );
endinterface

// File: rtl/if_neuron_scheduler.sv
// Shares one integrate-and-fire update path among N_NEURONS virtual neurons.
// Currents are buffered while idle; a step command sweeps neurons 0..N-1, one per
// evaluate cycle, emitting spike events on a valid/ready stream (one outstanding).
module if_neuron_scheduler #(
    parameter int         N_NEURONS = 8,
    parameter logic [7:0] THR_RESET = 8'hE6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    if_neuron_scheduler_if.slave bus
);
    localparam int            IW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);
    localparam logic [IW:0]   N_EXT    = (IW+1)'(N_NEURONS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fsm_t;

    fsm_t          fsm_r;
    fsm_t          fsm_nxt_s;
    logic [7:0]    mem_state_r [N_NEURONS];
    logic [7:0]    cur_buf_r   [N_NEURONS];
    logic [7:0]    thr_r;
    logic [IW-1:0] ptr_r;
    logic          spike_valid_r;
    logic [IW-1:0] spike_idx_r;
    logic          busy_r;
    logic          done_r;
    logic          cur_ready_r;
    logic [7:0]    rd_state_r;
    logic          busy_nxt_s;
    logic          done_nxt_s;
    logic          cur_ready_nxt_s;
    logic          slot_free_s;
    logic          eval_s;
    logic          flush_go_s;
    logic          spike_s;
    logic          cur_wr_s;
    logic          thr_wr_s;
    logic          rd_idx_ok_s;

    // Saturating 8-bit add used for current accumulation.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // The output slot is free when nothing is pending or the pending event is taken now.
    assign slot_free_s = !spike_valid_r || bus.spike_ready;
    assign eval_s      = (fsm_r == ST_SWEEP) && slot_free_s;
    assign flush_go_s  = (fsm_r == ST_FLUSH) && slot_free_s;
    assign spike_s     = eval_s && (mem_state_r[ptr_r] >= thr_r);
    assign cur_wr_s    = (fsm_r == ST_IDLE) && bus.cur_we && ({1'b0, bus.cur_idx} < N_EXT);
    assign thr_wr_s    = (fsm_r == ST_IDLE) && bus.thr_we;
    assign rd_idx_ok_s = ({1'b0, bus.rd_idx} < N_EXT);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r <= ST_IDLE;
        end else begin
            fsm_r <= fsm_nxt_s;
        end
    end

    // Next-state logic: sweep advances only on evaluate cycles, flush waits for the slot.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            ST_IDLE: begin
                if (bus.step_start) fsm_nxt_s = ST_SWEEP;
                else                fsm_nxt_s = ST_IDLE;
            end
            ST_SWEEP: begin
                if (eval_s && (ptr_r == LAST_IDX)) fsm_nxt_s = ST_FLUSH;
                else                               fsm_nxt_s = ST_SWEEP;
            end
            ST_FLUSH: begin
                if (flush_go_s) fsm_nxt_s = ST_DONE;
                else            fsm_nxt_s = ST_FLUSH;
            end
            ST_DONE:  fsm_nxt_s = ST_IDLE;
            default:  fsm_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done/cur_ready come straight from flops.
    always_comb begin
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b0;
        cur_ready_nxt_s = 1'b0;
        case (fsm_nxt_s)
            ST_IDLE:  cur_ready_nxt_s = 1'b1;
            ST_SWEEP: busy_nxt_s      = 1'b1;
            ST_FLUSH: busy_nxt_s      = 1'b1;
            ST_DONE: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            default:  cur_ready_nxt_s = 1'b0;
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cur_ready_r <= 1'b0;
        end else begin
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            cur_ready_r <= cur_ready_nxt_s;
        end
    end

    // Neuron storage: idle-time current accumulation and per-neuron update on evaluate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_state_r[i] <= 8'd0;
                cur_buf_r[i]   <= 8'd0;
            end
            thr_r <= THR_RESET;
        end else begin
            if (cur_wr_s) begin
                cur_buf_r[bus.cur_idx] <= sat_add8(cur_buf_r[bus.cur_idx], bus.cur_data);
            end
            if (thr_wr_s) begin
                thr_r <= bus.thr_data;
            end
            if (eval_s) begin
                // A firing neuron resets and does not integrate this step; membrane wraps.
                if (spike_s) mem_state_r[ptr_r] <= 8'd0;
                else         mem_state_r[ptr_r] <= mem_state_r[ptr_r] + cur_buf_r[ptr_r];
                cur_buf_r[ptr_r] <= 8'd0;
            end
        end
    end

    // Sweep pointer and single-entry spike event register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r         <= {IW{1'b0}};
            spike_valid_r <= 1'b0;
            spike_idx_r   <= {IW{1'b0}};
        end else begin
            if (fsm_r == ST_IDLE) begin
                ptr_r <= {IW{1'b0}};
            end else if (eval_s) begin
                ptr_r <= (ptr_r == LAST_IDX) ? {IW{1'b0}} : ptr_r + IW'(1);
            end
            if (eval_s && spike_s) begin
                spike_valid_r <= 1'b1;
                spike_idx_r   <= ptr_r;
            end else if ((eval_s || flush_go_s) && bus.spike_ready) begin
                spike_valid_r <= 1'b0;
            end
        end
    end

    // Registered membrane readback, pre-update during the evaluated neuron's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_r <= 8'd0;
        end else begin
            rd_state_r <= rd_idx_ok_s ? mem_state_r[bus.rd_idx] : 8'd0;
        end
    end

    assign bus.cur_ready   = cur_ready_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.spike_valid = spike_valid_r;
    assign bus.spike_idx   = spike_idx_r;
    assign bus.rd_state    = rd_state_r;
endmodule

// File: tb/tb_if_neuron_scheduler.sv
// Scoreboard bench for if_neuron_scheduler (N=8, threshold 0xE6).
// Stimulus pushes expected spike indices and sweep lengths; a negedge monitor pops them.
module tb_if_neuron_scheduler;
    localparam int N  = 8;
    localparam int IW = 3;

    logic clk;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   busy_cnt  = 0;
    int   spk_q[$];
    int   len_q[$];

    if_neuron_scheduler_if #(.IW(IW)) bus ();

    if_neuron_scheduler #(.N_NEURONS(N), .THR_RESET(8'hE6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: spike handshakes and done pulses are checked against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.spike_valid && bus.spike_ready) begin
                    if (spk_q.size() == 0) check("unexpected_spike", int'(bus.spike_idx), -1);
                    else check("spike_idx", int'(bus.spike_idx), spk_q.pop_front());
                end
                if (bus.done) begin
                    if (len_q.size() == 0) check("unexpected_done", busy_cnt, -1);
                    else check("sweep_len", busy_cnt, len_q.pop_front());
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic write_cur(input int idx, input int data);
        bus.cur_we = 1'b1; bus.cur_idx = IW'(idx); bus.cur_data = 8'(data);
        tick();
        bus.cur_we = 1'b0;
    endtask

    task automatic write_thr(input int data);
        bus.thr_we = 1'b1; bus.thr_data = 8'(data);
        tick();
        bus.thr_we = 1'b0;
    endtask

    task automatic read_state(input string name, input int idx, input int exp);
        bus.rd_idx = IW'(idx);
        tick();
        check(name, int'(bus.rd_state), exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", int'(bus.busy), 0);
    endtask

    task automatic run_step(input int exp_len);
        len_q.push_back(exp_len);
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_spike_valid"}, int'(bus.spike_valid), 0);
        check({tag, "_spike_idx"}, int'(bus.spike_idx), 0);
        check({tag, "_rd_state"}, int'(bus.rd_state), 0);
        check({tag, "_cur_ready"}, int'(bus.cur_ready), 0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.thr_we = 1'b0; bus.thr_data = 8'd0;
        bus.cur_we = 1'b0; bus.cur_idx = '0; bus.cur_data = 8'd0;
        bus.step_start = 1'b0; bus.spike_ready = 1'b1; bus.rd_idx = '0;
        #12;
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("cur_ready_after_reset", int'(bus.cur_ready), 1);
        for (int i = 0; i < N; i++) read_state("reset_state", i, 0);

        // Empty sweep: no spikes, N+2 cycles.
        run_step(10);

        // Integration: 100 per step on neuron 3 -> 100, 200, 44 (wrap).
        for (int s = 0; s < 3; s++) begin
            write_cur(3, 100);
            run_step(10);
        end
        for (int i = 0; i < N; i++) read_state("integrate_state", i, (i == 3) ? 44 : 0);

        // Spike on step 2 with current 0xE6: 230 >= 230, reset to 0, current not applied.
        reset_dut();
        write_cur(3, 8'hE6);
        run_step(10);
        read_state("pre_spike_state3", 3, 230);
        write_cur(3, 8'hE6);
        spk_q.push_back(3);
        run_step(10);
        read_state("post_spike_state3", 3, 0);
        run_step(10);
        read_state("cleared_buf_state3", 3, 0);

        // Saturation: 200 + 200 -> 255, then spike next step.
        write_cur(1, 200);
        write_cur(1, 200);
        run_step(10);
        read_state("sat_state1", 1, 255);
        spk_q.push_back(1);
        run_step(10);
        read_state("sat_spike_state1", 1, 0);

        // Backpressure: neurons 0, 2, 5 at threshold, 4 stall cycles after first event.
        write_cur(0, 8'hE6);
        write_cur(2, 8'hE6);
        write_cur(5, 8'hE6);
        run_step(10);
        read_state("bp_pre_state2", 2, 230);
        spk_q.push_back(0); spk_q.push_back(2); spk_q.push_back(5);
        len_q.push_back(14);
        bus.spike_ready = 1'b0;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        n = 0;
        while (!bus.spike_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_first_valid", int'(bus.spike_valid), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_valid", int'(bus.spike_valid), 1);
            check("bp_hold_idx", int'(bus.spike_idx), 0);
            check("bp_hold_state2", int'(bus.rd_state), 230);
        end
        bus.spike_ready = 1'b1;
        wait_idle();
        read_state("bp_state0", 0, 0);
        read_state("bp_state2", 2, 0);
        read_state("bp_state5", 5, 0);

        // Config gating: writes and step_start during busy are dropped.
        len_q.push_back(10);
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        tick();
        tick();
        bus.thr_we = 1'b1; bus.thr_data = 8'h10;
        bus.cur_we = 1'b1; bus.cur_idx = IW'(4); bus.cur_data = 8'd50;
        bus.step_start = 1'b1;
        tick();
        bus.thr_we = 1'b0; bus.cur_we = 1'b0; bus.step_start = 1'b0;
        wait_idle();
        tick();
        tick();
        check("no_second_sweep", int'(bus.busy), 0);
        run_step(10);
        read_state("gated_cur_state4", 4, 0);
        write_cur(4, 8'h20);
        run_step(10);
        read_state("idle_cur_state4", 4, 32);
        run_step(10);
        read_state("gated_thr_state4", 4, 32);
        write_thr(8'h10);
        spk_q.push_back(4);
        run_step(10);
        read_state("idle_thr_state4", 4, 0);

        // Async reset mid-sweep with an event pending (threshold now 0x10).
        write_cur(3, 8'h20);
        run_step(10);
        read_state("pre_rst_state3", 3, 32);
        bus.spike_ready = 1'b0;
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        n = 0;
        while (!bus.spike_valid && n < 20) begin
            tick();
            n++;
        end
        check("mid_rst_valid", int'(bus.spike_valid), 1);
        check("mid_rst_idx", int'(bus.spike_idx), 3);
        check("mid_rst_busy", int'(bus.busy), 1);
        reset_dut();
        bus.spike_ready = 1'b1;
        read_state("post_rst_state3", 3, 0);
        run_step(10);
        read_state("post_rst_sweep_state3", 3, 0);

        tick();
        check("spike_queue_empty", spk_q.size(), 0);
        check("len_queue_empty", len_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
